vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The module SHALL have the parameter H_TOTAL, default 800, meaning pixel clocks per line.
REQ-002 The module SHALL have the parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 The module SHALL have the parameter H_START, default 144, meaning clocks from hsync falling edge to the first active pixel.
REQ-004 The module SHALL have the parameter V_START, default 35, meaning lines from vsync to the first active line; active area is fixed at 640x480.
REQ-005 clk  input  1  pixel clock, one sample per rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 vga_h_sync  input  1  horizontal sync, active-low.
REQ-008 vga_v_sync  input  1  vertical sync, active-low.
REQ-009 vga_r, vga_g, vga_b  input  1 each  pixel colour bits.
REQ-010 pix_x  output  10  active-area column, 0..639.
REQ-011 pix_y  output  10  active-area row, 0..479.
REQ-012 pix_valid  output  1  pix_x, pix_y and pix_rgb are valid this cycle.
REQ-013 pix_rgb  output  3  {r,g,b} of the pixel.
REQ-014 frame_start  output  1  one-cycle pulse at the start of each frame.
REQ-015 locked  output  1  timing is locked.
REQ-016 err_count  output  8  count of timing errors, saturating.
REQ-017 lit_count  output  19  count of non-black active pixels in the last complete locked frame.

Function
REQ-018 All inputs SHALL be registered once; all processing SHALL use the registered copies.
REQ-019 hcnt (10 bit) SHALL be 0 on the first cycle the registered hsync is low after being high, SHALL otherwise increment, and SHALL saturate at 1023.
REQ-020 A falling edge of registered vsync SHALL set vs_pend.
REQ-021 On each hsync fall with vs_pend set, vcnt SHALL be set to 0, vs_pend SHALL be cleared, and frame_start SHALL pulse in that cycle.
REQ-022 On each hsync fall without vs_pend, vcnt SHALL increment, saturating at 1023.
REQ-023 Line error: at an hsync fall, previous hcnt+1 != H_TOTAL, excluding the first hsync fall after reset.
REQ-024 Frame error: at a frame start, previous vcnt+1 != V_TOTAL, excluding the first frame start after reset.
REQ-025 Each line or frame error SHALL increment err_count by 1, saturating at 255; a simultaneous line and frame error SHALL count 2, saturating.
REQ-026 Lock FSM states: UNLOCK, SYNC, LOCK; locked SHALL be 1 only in LOCK.
REQ-027 UNLOCK -> SYNC at a frame start.
REQ-028 SYNC -> LOCK at the next frame start with no error during the intervening frame.
REQ-029 SYNC or LOCK -> UNLOCK on any line or frame error, with that event taking priority over a same-cycle frame start.
REQ-030 pix_valid SHALL be 1 iff locked, H_START <= hcnt < H_START+640 and V_START <= vcnt < V_START+480.
REQ-031 pix_x SHALL equal hcnt-H_START and pix_y SHALL equal vcnt-V_START.
REQ-032 pix_valid, pix_x, pix_y and pix_rgb SHALL be registered, giving 2 clocks latency from the input pins.
REQ-033 An internal 19-bit accumulator SHALL increment on every pix_valid cycle with pix_rgb != 0.
REQ-034 At a frame start while in LOCK, the accumulator SHALL be copied to lit_count and cleared; at other frame starts the accumulator SHALL be cleared and lit_count held.
REQ-035 A loss of lock mid-frame SHALL deassert pix_valid on the next cycle and SHALL discard that frame's accumulation.

Reset
REQ-036 reset_n low SHALL asynchronously force state UNLOCK and all counters, vs_pend and the first-edge flags to 0.
REQ-037 reset_n low SHALL asynchronously force all outputs to 0 (pix_x, pix_y, pix_valid, pix_rgb, frame_start, locked, err_count, lit_count).
REQ-038 Reset release SHALL be synchronous to clk; a reset mid-frame SHALL require the full UNLOCK -> SYNC -> LOCK sequence again.

Verification
REQ-039 Nominal 800x525 timing, all-white, 3 frames -> locked=1 at the 2nd frame_start; lit_count=307200 after the 3rd; err_count=0.
REQ-040 Locked, one line of 799 clocks -> err_count=1, locked=0 next cycle, pix_valid=0; relock after 2 good frame starts.
REQ-041 Locked, red only on the pixel at x=0,y=0 -> pix_valid with pix_x=0, pix_y=0, pix_rgb=3'b100 exactly 2 clocks after the pixel is driven on the pins; lit_count=1.
REQ-042 Frame of 524 lines -> frame error counted, err_count=1, lit_count unchanged from the prior frame.
REQ-043 Hsync held low/high for more than 1024 clocks -> hcnt saturates; the next hsync fall is a line error; 300 such errors -> err_count=255.
REQ-044 Assert reset_n=0 mid-frame while locked -> all outputs 0 immediately; after release locked=0 until the second subsequent frame_start.

Source files
------------

// File: rtl/vga_capture.sv
// VGA timing capture: recovers active-area pixel coordinates from the sync inputs,
// tracks timing lock, counts timing errors and the lit pixels of each locked frame.
module vga_capture #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int H_START = 144,
    parameter int V_START = 35
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_count,
    output logic [18:0] lit_count
);

    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] H_BEG_W   = 11'(H_START);
    localparam logic [10:0] H_END_W   = 11'(H_START) + 11'd640;
    localparam logic [10:0] V_BEG_W   = 11'(V_START);
    localparam logic [10:0] V_END_W   = 11'(V_START) + 11'd480;
    localparam logic [9:0]  H_OFS     = 10'(H_START);
    localparam logic [9:0]  V_OFS     = 10'(V_START);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        SYNC   = 2'd1,
        LOCK   = 2'd2
    } lock_state_t;

    logic        rst_meta_r;
    logic        rst_sync_r;
    logic        hs_r;
    logic        hs_d_r;
    logic        vs_r;
    logic        vs_d_r;
    logic [2:0]  rgb_r;
    logic [9:0]  hcnt_r;
    logic [9:0]  vcnt_r;
    logic        vs_pend_r;
    logic        seen_hs_r;
    logic        seen_fs_r;
    logic [18:0] acc_r;
    lock_state_t state_r;

    logic        hs_fall_s;
    logic        vs_fall_s;
    logic        vs_pend_s;
    logic        fstart_s;
    logic [9:0]  hcnt_s;
    logic [9:0]  vcnt_s;
    logic        line_err_s;
    logic        frame_err_s;
    logic        err_s;
    logic [1:0]  err_inc_s;
    logic [8:0]  err_sum_s;
    logic [7:0]  err_nxt_s;
    logic        lock_nxt_s;
    logic        in_win_s;
    logic        valid_s;
    logic        lit_pix_s;
    logic [9:0]  pix_x_s;
    logic [9:0]  pix_y_s;
    lock_state_t state_nxt_s;

    // Reset synchroniser: assertion is immediate, release waits for two clock edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Input capture plus one extra stage of the syncs for edge detection
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            hs_r   <= 1'b0;
            hs_d_r <= 1'b0;
            vs_r   <= 1'b0;
            vs_d_r <= 1'b0;
            rgb_r  <= 3'd0;
        end else begin
            hs_r   <= vga_h_sync;
            hs_d_r <= hs_r;
            vs_r   <= vga_v_sync;
            vs_d_r <= vs_r;
            rgb_r  <= {vga_r, vga_g, vga_b};
        end
    end

    // Timing counters, error detection and pixel window for the current captured sample
    always_comb begin
        hs_fall_s   = hs_d_r & ~hs_r;
        vs_fall_s   = vs_d_r & ~vs_r;
        // A vsync fall coinciding with an hsync fall starts the frame on that line
        vs_pend_s   = vs_pend_r | vs_fall_s;
        fstart_s    = hs_fall_s & vs_pend_s;
        hcnt_s      = hcnt_r;
        vcnt_s      = vcnt_r;
        if (hs_fall_s) begin
            hcnt_s = 10'd0;
        end else if (hcnt_r != 10'd1023) begin
            hcnt_s = hcnt_r + 10'd1;
        end else begin
            hcnt_s = hcnt_r;
        end
        if (fstart_s) begin
            vcnt_s = 10'd0;
        end else if (hs_fall_s && (vcnt_r != 10'd1023)) begin
            vcnt_s = vcnt_r + 10'd1;
        end else begin
            vcnt_s = vcnt_r;
        end
        line_err_s  = hs_fall_s & seen_hs_r & (({1'b0, hcnt_r} + 11'd1) != H_TOTAL_W);
        frame_err_s = fstart_s & seen_fs_r & (({1'b0, vcnt_r} + 11'd1) != V_TOTAL_W);
        err_s       = line_err_s | frame_err_s;
        err_inc_s   = {1'b0, line_err_s} + {1'b0, frame_err_s};
        err_sum_s   = {1'b0, err_count} + {7'd0, err_inc_s};
        err_nxt_s   = err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
        in_win_s    = ({1'b0, hcnt_s} >= H_BEG_W) && ({1'b0, hcnt_s} < H_END_W) &&
                      ({1'b0, vcnt_s} >= V_BEG_W) && ({1'b0, vcnt_s} < V_END_W);
        pix_x_s     = hcnt_s - H_OFS;
        pix_y_s     = vcnt_s - V_OFS;
    end

    // Lock FSM next state; errors win over a coincident frame start
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            UNLOCK: begin
                if (fstart_s) state_nxt_s = SYNC;
                else          state_nxt_s = UNLOCK;
            end
            SYNC: begin
                if (err_s)         state_nxt_s = UNLOCK;
                else if (fstart_s) state_nxt_s = LOCK;
                else               state_nxt_s = SYNC;
            end
            LOCK: begin
                if (err_s) state_nxt_s = UNLOCK;
                else       state_nxt_s = LOCK;
            end
            default: state_nxt_s = UNLOCK;
        endcase
        // Using the next state drops pix_valid in the same cycle that locked falls
        lock_nxt_s = (state_nxt_s == LOCK);
        valid_s    = lock_nxt_s & in_win_s;
        lit_pix_s  = valid_s & (rgb_r != 3'd0);
    end

    // Counter, frame bookkeeping and lock state registers
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            hcnt_r    <= 10'd0;
            vcnt_r    <= 10'd0;
            vs_pend_r <= 1'b0;
            seen_hs_r <= 1'b0;
            seen_fs_r <= 1'b0;
            state_r   <= UNLOCK;
        end else begin
            hcnt_r    <= hcnt_s;
            vcnt_r    <= vcnt_s;
            vs_pend_r <= vs_pend_s & ~fstart_s;
            seen_hs_r <= seen_hs_r | hs_fall_s;
            seen_fs_r <= seen_fs_r | fstart_s;
            state_r   <= state_nxt_s;
        end
    end

    // Lit-pixel accumulator; only a frame that stayed locked to its end is published
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            acc_r     <= 19'd0;
            lit_count <= 19'd0;
        end else begin
            if (fstart_s && (state_r == LOCK) && !err_s) begin
                lit_count <= acc_r;
            end else begin
                lit_count <= lit_count;
            end
            if (fstart_s || err_s) begin
                acc_r <= 19'd0;
            end else if (lit_pix_s) begin
                acc_r <= acc_r + 19'd1;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Registered outputs, one stage after the captured inputs
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_valid   <= 1'b0;
            pix_rgb     <= 3'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            pix_x       <= pix_x_s;
            pix_y       <= pix_y_s;
            pix_valid   <= valid_s;
            pix_rgb     <= rgb_r;
            frame_start <= fstart_s;
            locked      <= lock_nxt_s;
            err_count   <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shortened 660x5 frame so the
// column boundary 639/640 is reachable within a small cycle budget.
module tb_vga_capture;

    localparam int HT = 660;
    localparam int VT = 5;
    localparam int HS = 8;
    localparam int VS = 2;
    localparam int NP = 8;
    localparam int PROBE_FRAME = 4;

    logic        clk;
    logic        reset_n;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic [2:0]  pix_rgb;
    logic        frame_start;
    logic        locked;
    logic [7:0]  err_count;
    logic [18:0] lit_count;

    vga_capture #(
        .H_TOTAL(HT),
        .V_TOTAL(VT),
        .H_START(HS),
        .V_START(VS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vga_h_sync (vga_h_sync),
        .vga_v_sync (vga_v_sync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .frame_start(frame_start),
        .locked     (locked),
        .err_count  (err_count),
        .lit_count  (lit_count)
    );

    typedef struct {
        int         h;
        int         v;
        logic [2:0] rgb;
        logic       exp_valid;
        logic [9:0] exp_x;
        logic [9:0] exp_y;
    } probe_t;

    probe_t probes[NP];

    int   checks = 0;
    int   failures = 0;
    int   fs_cnt = 0;
    int   valid_cnt = 0;
    logic fs_lock[64];
    int   cur_frame = 0;
    int   h0 = -1, h1 = -1, h2 = -1;
    int   v0 = -1, v1 = -1, v2 = -1;
    int   f0 = -1, f1 = -1, f2 = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record lock status at every frame_start pulse and count valid pixels
    always @(negedge clk) begin
        if (frame_start === 1'b1) begin
            if (fs_cnt < 64) fs_lock[fs_cnt] = locked;
            fs_cnt = fs_cnt + 1;
        end
        if (pix_valid === 1'b1) valid_cnt = valid_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] probe_rgb(input int h, input int v);
        logic [2:0] c;
        c = 3'b000;
        for (int i = 0; i < NP; i++) begin
            if (probes[i].h == h && probes[i].v == v) c = probes[i].rgb;
        end
        return c;
    endfunction

    // One pixel clock; outputs sampled here belong to the drive two clocks earlier
    task automatic step(input logic hs, input logic vs, input logic [2:0] rgb, input int h, input int v);
        @(posedge clk);
        #1;
        vga_h_sync = hs;
        vga_v_sync = vs;
        {vga_r, vga_g, vga_b} = rgb;
        h2 = h1; v2 = v1; f2 = f1;
        h1 = h0; v1 = v0; f1 = f0;
        h0 = h;  v0 = v;  f0 = cur_frame;
        @(negedge clk);
        if (f2 == PROBE_FRAME) begin
            for (int i = 0; i < NP; i++) begin
                if (probes[i].h == h2 && probes[i].v == v2) begin
                    check($sformatf("probe%0d_valid", i), {31'd0, pix_valid}, {31'd0, probes[i].exp_valid});
                    if (probes[i].exp_valid) begin
                        check($sformatf("probe%0d_x", i), {22'd0, pix_x}, {22'd0, probes[i].exp_x});
                        check($sformatf("probe%0d_y", i), {22'd0, pix_y}, {22'd0, probes[i].exp_y});
                        check($sformatf("probe%0d_rgb", i), {29'd0, pix_rgb}, {29'd0, probes[i].rgb});
                    end
                end
            end
        end
    endtask

    // mode 0 black, 1 white, 2 probe table; short_v selects a line one clock short
    task automatic run_frame(input int lines, input int short_v, input int mode);
        logic [2:0] c;
        int len;
        cur_frame = cur_frame + 1;
        for (int v = 0; v < lines; v++) begin
            len = (v == short_v) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                if (mode == 1)      c = 3'b111;
                else if (mode == 2) c = probe_rgb(h, v);
                else                c = 3'b000;
                step((h < 4) ? 1'b0 : 1'b1, (v == 0) ? 1'b0 : 1'b1, c, h, v);
            end
        end
    endtask

    task automatic drive_line(input int low_len, input int total);
        for (int i = 0; i < total; i++) begin
            step((i < low_len) ? 1'b0 : 1'b1, 1'b1, 3'b000, -1, -1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_x"}, {22'd0, pix_x}, 32'd0);
        check({tag, "_pix_y"}, {22'd0, pix_y}, 32'd0);
        check({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        check({tag, "_pix_rgb"}, {29'd0, pix_rgb}, 32'd0);
        check({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
        check({tag, "_lit_count"}, {13'd0, lit_count}, 32'd0);
    endtask

    initial begin
        int exp_lit;
        int base;
        int fs_base;

        probes[0] = '{h: HS,       v: VS,     rgb: 3'b100, exp_valid: 1'b1, exp_x: 10'd0,   exp_y: 10'd0};
        probes[1] = '{h: HS + 639, v: VS,     rgb: 3'b010, exp_valid: 1'b1, exp_x: 10'd639, exp_y: 10'd0};
        probes[2] = '{h: HS + 640, v: VS,     rgb: 3'b111, exp_valid: 1'b0, exp_x: 10'd0,   exp_y: 10'd0};
        probes[3] = '{h: HS - 1,   v: VS + 1, rgb: 3'b111, exp_valid: 1'b0, exp_x: 10'd0,   exp_y: 10'd0};
        probes[4] = '{h: 300,      v: VS - 1, rgb: 3'b001, exp_valid: 1'b0, exp_x: 10'd0,   exp_y: 10'd0};
        probes[5] = '{h: HS + 1,   v: VS + 2, rgb: 3'b000, exp_valid: 1'b1, exp_x: 10'd1,   exp_y: 10'd2};
        probes[6] = '{h: 100,      v: VS + 1, rgb: 3'b000, exp_valid: 1'b1, exp_x: 10'd92,  exp_y: 10'd1};
        probes[7] = '{h: HT - 1,   v: VT - 1, rgb: 3'b101, exp_valid: 1'b0, exp_x: 10'd0,   exp_y: 10'd0};
        exp_lit = 0;
        for (int i = 0; i < NP; i++) begin
            if (probes[i].exp_valid && probes[i].rgb != 3'b000) exp_lit = exp_lit + 1;
        end

        reset_n = 1'b0;
        vga_h_sync = 1'b1;
        vga_v_sync = 1'b1;
        {vga_r, vga_g, vga_b} = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'b000, -1, -1);

        // Three white frames: lock at the second frame start, publish at the third
        run_frame(VT, -1, 1);
        run_frame(VT, -1, 1);
        run_frame(VT, -1, 1);
        check("nominal_fs_count", fs_cnt, 32'd3);
        check("nominal_fs1_locked", {31'd0, fs_lock[0]}, 32'd0);
        check("nominal_fs2_locked", {31'd0, fs_lock[1]}, 32'd1);
        check("nominal_lit", {13'd0, lit_count}, 32'd1920);
        check("nominal_err", {24'd0, err_count}, 32'd0);
        check("nominal_valid_cycles", valid_cnt, 32'd3840);

        // Probe frame: boundary pixels and 2-clock latency via the table
        run_frame(VT, -1, 2);
        check("probe_prev_lit", {13'd0, lit_count}, 32'd1920);

        // White frame with a line one clock short in the active area
        base = valid_cnt;
        run_frame(VT, VS + 1, 1);
        check("short_line_lit", {13'd0, lit_count}, exp_lit);
        check("short_line_err", {24'd0, err_count}, 32'd1);
        check("short_line_locked", {31'd0, locked}, 32'd0);
        check("short_line_valid_cycles", valid_cnt - base, 32'd1280);
        run_frame(VT, -1, 1);
        check("relock1_locked", {31'd0, locked}, 32'd0);
        check("relock1_fs_locked", {31'd0, fs_lock[5]}, 32'd0);
        check("discard_lit", {13'd0, lit_count}, exp_lit);
        run_frame(VT, -1, 1);
        check("relock2_fs_locked", {31'd0, fs_lock[6]}, 32'd1);
        check("relock2_locked", {31'd0, locked}, 32'd1);

        // Four-line frame whose last line is short: line and frame error together
        run_frame(VT - 1, VT - 2, 1);
        check("short_frame_prev_lit", {13'd0, lit_count}, 32'd1920);
        run_frame(VT, -1, 1);
        check("frame_err_count", {24'd0, err_count}, 32'd3);
        check("frame_err_lit_held", {13'd0, lit_count}, 32'd1920);
        check("frame_err_fs_locked", {31'd0, fs_lock[8]}, 32'd0);
        check("frame_err_locked", {31'd0, locked}, 32'd0);
        run_frame(VT, -1, 1);
        run_frame(VT, -1, 1);
        check("relock3_locked", {31'd0, locked}, 32'd1);

        // Reset in the middle of an active line while locked
        run_frame(VT - 2, -1, 1);
        for (int h = 0; h < 300; h++) step((h < 4) ? 1'b0 : 1'b1, 1'b1, 3'b111, h, VT - 2);
        check("pre_reset_valid", {31'd0, pix_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'b000, -1, -1);
        fs_base = fs_cnt;
        run_frame(VT, -1, 1);
        check("post_reset_locked", {31'd0, locked}, 32'd0);
        run_frame(VT, -1, 1);
        check("post_reset_fs_count", fs_cnt - fs_base, 32'd2);
        check("post_reset_fs1_locked", {31'd0, fs_lock[fs_base]}, 32'd0);
        check("post_reset_fs2_locked", {31'd0, fs_lock[fs_base + 1]}, 32'd1);
        check("post_reset_err", {24'd0, err_count}, 32'd0);
        check("post_reset_lit", {13'd0, lit_count}, 32'd0);

        // Lines of 1684 clocks: only a saturating hcnt makes them errors
        drive_line(1100, 1684);
        check("long_low_err0", {24'd0, err_count}, 32'd0);
        drive_line(5, 1684);
        check("long_low_err1", {24'd0, err_count}, 32'd1);
        check("long_low_locked", {31'd0, locked}, 32'd0);
        drive_line(5, 1684);
        check("long_high_err2", {24'd0, err_count}, 32'd2);
        for (int i = 0; i < 100; i++) drive_line(2, 10);
        check("err_count_102", {24'd0, err_count}, 32'd102);
        for (int i = 0; i < 198; i++) drive_line(2, 10);
        check("err_count_sat", {24'd0, err_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
